// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester frame transmitter and its matching decoder:
// FSM state encoding, line-polarity constants and the half-bit level helper.
package manchester_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SYNC     = 3'd2,
        S_DATA     = 3'd3,
        S_STOP     = 3'd4
    } mtx_state_e;

    localparam logic POL_IEEE   = 1'b0;
    localparam logic POL_THOMAS = 1'b1;

    // IEEE: a 0 is sent high then low, a 1 low then high; Thomas inverts both halves.
    function automatic logic manchester_level(input logic bit_val,
                                              input logic second_half,
                                              input logic pol);
        return bit_val ^ ~second_half ^ pol;
    endfunction

endpackage

// File: rtl/manchester_fifo.sv
// Synchronous show-ahead FIFO with a registered occupancy count.
// The head word is visible on o_rd_data before it is popped.
module manchester_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Fullness comes from the registered count, so a pop never makes room for a same-cycle push.
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push    = i_wr_en & ~o_full;
    assign w_pop     = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/manchester_frame_tx.sv
// Buffered Manchester frame transmitter: preamble, sync violation, back-to-back data words, stop.
// Line level, encoding flag and FSM position are all registered on the same clk16x edge.
module manchester_frame_tx
    import manchester_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int OSR           = 16,
    parameter int PREAMBLE_BITS = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk16x,
    input  logic                          resetn,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          write_en,
    output logic                          ready,
    output logic                          overflow,
    input  logic                          polarity,
    input  logic                          msb_first,
    output logic                          encoding,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx
);

    localparam int CNT_W   = $clog2(OSR);
    localparam int BIT_MAX = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
    localparam int BIT_W   = (BIT_MAX > 2) ? $clog2(BIT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(OSR / 2);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(1);

    mtx_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_word;
    logic              r_pol;
    logic              r_msb;
    logic              r_tx;
    logic              r_enc;
    logic              r_overflow;

    mtx_state_e        w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [BIT_W-1:0]  w_bit;
    logic [BIT_W-1:0]  w_bit_inc;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_head;
    logic              w_last;
    logic              w_second;
    logic              w_tx;
    logic              w_enc;
    logic              w_pop;
    logic              w_latch;
    logic              w_full;
    logic              w_empty;

    function automatic logic word_bit(input logic [DATA_W-1:0] word,
                                      input logic [BIT_W-1:0]  idx,
                                      input logic              msb);
        int                pos;
        logic [DATA_W-1:0] shifted;
        pos     = msb ? (DATA_W - 1 - int'(idx)) : int'(idx);
        shifted = word >> pos;
        return shifted[0];
    endfunction

    manchester_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk16x),
        .i_rstn    (resetn),
        .i_wr_en   (write_en),
        .i_wr_data (data_in),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (fifo_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign ready    = ~w_full;
    assign overflow = r_overflow;
    assign encoding = r_enc;
    assign tx       = r_tx;

    // Next-state logic computes the line level for the cycle being entered,
    // so tx changes on the same edge as the counters that describe it.
    always_comb begin
        w_cnt_inc = r_cnt + 1'b1;
        w_bit_inc = r_bit + 1'b1;
        w_last    = (r_cnt == CNT_LAST);
        w_second  = (w_cnt_inc >= CNT_HALF);
        w_state   = r_state;
        w_cnt     = w_cnt_inc;
        w_bit     = r_bit;
        w_word    = r_word;
        w_enc     = r_enc;
        w_tx      = 1'b0;
        w_pop     = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                w_bit = '0;
                if (!w_empty) begin
                    w_state = S_PREAMBLE;
                    w_enc   = 1'b1;
                    w_latch = 1'b1;
                    w_tx    = manchester_level(1'b1, 1'b0, polarity);
                end
            end
            S_PREAMBLE: begin
                // Preamble bit k is 1 for even k, so its value is the inverted LSB of the index.
                if (!w_last) begin
                    w_tx = manchester_level(~r_bit[0], w_second, r_pol);
                end else if (r_bit == PRE_LAST) begin
                    w_state = S_SYNC;
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_tx    = 1'b1;
                end else begin
                    w_cnt = '0;
                    w_bit = w_bit_inc;
                    w_tx  = manchester_level(~w_bit_inc[0], 1'b0, r_pol);
                end
            end
            S_SYNC: begin
                if (!w_last) begin
                    w_tx = 1'b1;
                end else begin
                    w_state = S_DATA;
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_pop   = 1'b1;
                    w_word  = w_head;
                    w_tx    = manchester_level(word_bit(w_head, '0, r_msb), 1'b0, r_pol);
                end
            end
            S_DATA: begin
                if (!w_last) begin
                    w_tx = manchester_level(word_bit(r_word, r_bit, r_msb), w_second, r_pol);
                end else if (r_bit != DATA_LAST) begin
                    w_cnt = '0;
                    w_bit = w_bit_inc;
                    w_tx  = manchester_level(word_bit(r_word, w_bit_inc, r_msb), 1'b0, r_pol);
                end else if (!w_empty) begin
                    w_cnt  = '0;
                    w_bit  = '0;
                    w_pop  = 1'b1;
                    w_word = w_head;
                    w_tx   = manchester_level(word_bit(w_head, '0, r_msb), 1'b0, r_pol);
                end else begin
                    w_state = S_STOP;
                    w_cnt   = '0;
                    w_bit   = '0;
                end
            end
            S_STOP: begin
                // Two bit periods of low line, counted as two OSR-long slots.
                if (w_last) begin
                    w_cnt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_state = S_IDLE;
                        w_enc   = 1'b0;
                        w_bit   = '0;
                    end else begin
                        w_bit = w_bit_inc;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_enc   = 1'b0;
                w_cnt   = '0;
                w_bit   = '0;
            end
        endcase
    end

    always_ff @(posedge clk16x) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_pol      <= POL_IEEE;
            r_msb      <= 1'b0;
            r_tx       <= 1'b0;
            r_enc      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit      <= w_bit;
            r_tx       <= w_tx;
            r_enc      <= w_enc;
            r_overflow <= write_en & w_full;
            if (w_latch) begin
                r_pol <= polarity;
                r_msb <= msb_first;
            end
        end
    end

    always_ff @(posedge clk16x) begin
        r_word <= w_word;
    end

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Bench for manchester_frame_tx: directed and randomized frames checked against a
// waveform model built from the line-coding rules, plus reset and buffer-limit cases.
module tb_manchester_frame_tx;

    localparam int DATA_W = 8;
    localparam int OSR    = 16;
    localparam int PRE    = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int BUDGET = 4000;

    logic              clk16x    = 1'b0;
    logic              resetn    = 1'b0;
    logic [DATA_W-1:0] data_in   = '0;
    logic              write_en  = 1'b0;
    logic              polarity  = 1'b0;
    logic              msb_first = 1'b0;
    logic              ready;
    logic              overflow;
    logic              encoding;
    logic              tx;
    logic [CW-1:0]     fifo_count;

    int n_assert   = 0;
    int n_fail     = 0;
    int frames     = 0;
    int ovf_pulses = 0;
    int model_cnt  = 0;
    int n_rej      = 0;
    logic enc_d    = 1'b0;

    logic              cap[$];
    logic              exp_q[$];
    logic [DATA_W-1:0] acc_q[$];
    logic [DATA_W-1:0] stim_q[$];

    always #5 clk16x = ~clk16x;

    manchester_frame_tx #(
        .DATA_W        (DATA_W),
        .OSR           (OSR),
        .PREAMBLE_BITS (PRE),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk16x     (clk16x),
        .resetn     (resetn),
        .data_in    (data_in),
        .write_en   (write_en),
        .ready      (ready),
        .overflow   (overflow),
        .polarity   (polarity),
        .msb_first  (msb_first),
        .encoding   (encoding),
        .fifo_count (fifo_count),
        .tx         (tx)
    );

    // Line monitor: records tx while a frame is on the line, counts frames and overflow pulses.
    always @(posedge clk16x) begin
        #1;
        if (encoding && !enc_d) frames++;
        if (encoding) cap.push_back(tx);
        if (overflow) ovf_pulses++;
        enc_d = encoding;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk16x);
        #3;
    endtask

    task automatic add_bit(input logic b, input logic pol);
        logic first;
        first = pol ? b : !b;
        repeat (OSR / 2) exp_q.push_back(first);
        repeat (OSR / 2) exp_q.push_back(!first);
    endtask

    task automatic build_frame(input logic pol, input logic msb);
        for (int k = 0; k < PRE; k++) add_bit(k % 2 == 0, pol);
        repeat (OSR) exp_q.push_back(1'b1);
        foreach (acc_q[w])
            for (int i = 0; i < DATA_W; i++)
                add_bit(msb ? acc_q[w][DATA_W-1-i] : acc_q[w][i], pol);
        repeat (2 * OSR) exp_q.push_back(1'b0);
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        logic acc;
        acc = (model_cnt < DEPTH);
        chk("ready_before_write", ready, acc);
        data_in  = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        if (acc) begin
            acc_q.push_back(d);
            model_cnt++;
        end else begin
            n_rej++;
        end
        chk("overflow_after_write", overflow, !acc);
    endtask

    task automatic start_frame(input logic pol, input logic msb);
        cap.delete();
        exp_q.delete();
        acc_q.delete();
        frames     = 0;
        ovf_pulses = 0;
        model_cnt  = 0;
        n_rej      = 0;
        polarity   = pol;
        msb_first  = msb;
        foreach (stim_q[i]) write_word(stim_q[i]);
        chk("fifo_count_after_writes", fifo_count, model_cnt);
        tick();
        build_frame(pol, msb);
    endtask

    task automatic finish_frame(input int nframes, input logic scramble);
        int c;
        int bad;
        c = 0;
        while (!((frames >= nframes) && !encoding) && c < BUDGET) begin
            if (scramble) begin
                polarity  = 1'($urandom_range(0, 1));
                msb_first = 1'($urandom_range(0, 1));
            end
            tick();
            c++;
        end
        chk("frame_done_in_budget", c < BUDGET, 1'b1);
        chk("frame_count", frames, nframes);
        chk("frame_length", cap.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
            if (cap[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        chk("first_wrong_tx_cycle", bad, -1);
        chk("overflow_pulse_count", ovf_pulses, n_rej);
    endtask

    // Independent receiver: the second half of each data bit carries the bit (IEEE) or its inverse.
    task automatic check_decode(input logic pol, input logic msb);
        int                base;
        int                idx;
        int                errs;
        logic              b;
        logic [DATA_W-1:0] word;
        base = PRE * OSR + OSR;
        errs = 0;
        foreach (acc_q[w]) begin
            word = '0;
            for (int i = 0; i < DATA_W; i++) begin
                idx = base + (w * DATA_W + i) * OSR;
                if (idx + OSR > cap.size()) begin
                    errs++;
                end else begin
                    if (cap[idx] === cap[idx + OSR/2]) errs++;
                    b = cap[idx + OSR/2] ^ pol;
                    if (msb) word[DATA_W-1-i] = b;
                    else     word[i] = b;
                end
            end
            chk("decoded_word", word, acc_q[w]);
        end
        chk("decode_errors", errs, 0);
    endtask

    initial begin
        int   c;
        int   n;
        logic p;
        logic m;

        resetn = 1'b0;
        repeat (3) tick();
        chk("reset_tx", tx, 1'b0);
        chk("reset_encoding", encoding, 1'b0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_ready", ready, 1'b1);
        chk("reset_overflow", overflow, 1'b0);
        resetn = 1'b1;
        tick();

        stim_q.delete();
        stim_q.push_back(8'hAC);
        start_frame(1'b0, 1'b1);
        finish_frame(1, 1'b0);
        chk("single_word_frame_cycles", cap.size(), 304);
        check_decode(1'b0, 1'b1);

        start_frame(1'b1, 1'b0);
        finish_frame(1, 1'b0);
        check_decode(1'b1, 1'b0);

        stim_q.delete();
        stim_q.push_back(8'h12);
        stim_q.push_back(8'h34);
        stim_q.push_back(8'h56);
        start_frame(1'b0, 1'b1);
        finish_frame(1, 1'b0);
        chk("three_word_frame_cycles", cap.size(), 560);
        check_decode(1'b0, 1'b1);

        stim_q.delete();
        for (int i = 0; i < 5; i++) stim_q.push_back(DATA_W'($urandom));
        p = 1'($urandom_range(0, 1));
        m = 1'($urandom_range(0, 1));
        start_frame(p, m);
        finish_frame(1, 1'b0);
        chk("five_writes_overflow_pulses", ovf_pulses, 1);
        chk("five_writes_words_sent", acc_q.size(), 4);
        check_decode(p, m);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 5);
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(DATA_W'($urandom));
            p = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            start_frame(p, m);
            finish_frame(1, 1'b1);
            check_decode(p, m);
        end

        // A word written while the stop bits are on the line gets its own full frame.
        stim_q.delete();
        stim_q.push_back(8'h5A);
        start_frame(1'b0, 1'b0);
        acc_q.delete();
        model_cnt = 0;
        c = 0;
        while (cap.size() < PRE*OSR + OSR + DATA_W*OSR + 6 && c < BUDGET) begin
            tick();
            c++;
        end
        chk("reached_stop_in_budget", c < BUDGET, 1'b1);
        write_word(8'hC3);
        build_frame(1'b0, 1'b0);
        finish_frame(2, 1'b0);

        // Reset in the middle of data bit 3 of the first of two buffered words.
        stim_q.delete();
        stim_q.push_back(8'hE7);
        stim_q.push_back(8'h18);
        start_frame(1'b0, 1'b1);
        c = 0;
        while (cap.size() < PRE*OSR + OSR + 3*OSR + 4 && c < BUDGET) begin
            tick();
            c++;
        end
        chk("reached_data_bit3_in_budget", c < BUDGET, 1'b1);
        resetn = 1'b0;
        tick();
        chk("midframe_reset_tx", tx, 1'b0);
        chk("midframe_reset_encoding", encoding, 1'b0);
        chk("midframe_reset_fifo_count", fifo_count, 0);
        chk("midframe_reset_ready", ready, 1'b1);
        resetn = 1'b1;
        repeat (4) tick();
        chk("no_resume_after_reset", encoding, 1'b0);
        stim_q.delete();
        stim_q.push_back(8'h96);
        start_frame(1'b1, 1'b1);
        finish_frame(1, 1'b0);
        chk("post_reset_frame_cycles", cap.size(), 304);
        check_decode(1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
